// File: rtl/frame_gen_pkg.sv
// Shared state encoding and CRC-8 helper for the test-frame generator.
package frame_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAP  = 3'd1,
    ST_DATA = 3'd2,
    ST_CRC  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // MSB-first CRC-8 over one byte: no reflection, no final XOR.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ poly;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_byte_unit.sv
// Running CRC-8 register with seed/enable; crc_nxt_o is the CRC including byte_i.
module crc8_byte_unit
  import frame_gen_pkg::*;
#(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       seed_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] crc_nxt_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  assign crc_nxt_o = crc8_next(crc_q, byte_i, POLY);

  // Seed has priority so a frame never inherits the previous frame's remainder.
  always_comb begin
    crc_d = crc_q;
    if (seed_i) begin
      crc_d = INIT;
    end else if (en_i) begin
      crc_d = crc_nxt_o;
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

endmodule

// File: rtl/frame_gen_stream.sv
// Test-frame generator: after a trigger and a fixed gap, streams len bytes of one
// status slot MSB-first over valid/ready, optionally followed by a CRC-8 trailer.
module frame_gen_stream
  import frame_gen_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter int          SRC_BYTES = 64,
  parameter int          GAP_CYC   = 50,
  parameter int          CRC_EN    = 1,
  parameter logic [7:0]  CRC_POLY  = 8'h07,
  parameter logic [7:0]  CRC_INIT  = 8'h00,
  localparam int         SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int         LEN_W     = $clog2(SRC_BYTES + 1)
) (
  input  logic                           sys_clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [SEL_W-1:0]               src_sel_i,
  input  logic [LEN_W-1:0]               len_i,
  input  logic [NUM_SRC*SRC_BYTES*8-1:0] src_data_i,
  output logic [7:0]                     data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic                           sof_o,
  output logic                           eof_o,
  output logic                           busy_o,
  output logic                           err_o,
  output logic                           drop_o
);

  localparam int SLOT_W = SRC_BYTES * 8;
  localparam int TOT_W  = NUM_SRC * SLOT_W;
  localparam int OFF_W  = $clog2(TOT_W);
  localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_e             state_q, state_d;
  logic               start_q;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic [7:0]         data_q, data_d;
  logic               sof_q, sof_d;
  logic               eof_q, eof_d;
  logic               busy_q;
  logic               err_q, err_d;
  logic               drop_q, drop_d;

  logic               trig_s;
  logic               req_ok_s;
  logic               last_s;
  logic               next_last_s;
  logic [LEN_W-1:0]   load_idx_s;
  logic [LEN_W-1:0]   byte_pos_s;
  logic [OFF_W-1:0]   off_s;
  logic [7:0]         payload_s;
  logic [7:0]         crc_nxt_s;
  logic               crc_seed_s;
  logic               crc_en_s;

  assign trig_s   = start_i & ~start_q;
  assign req_ok_s = (len_i != '0) && (32'(len_i) <= 32'(SRC_BYTES))
                    && (32'(src_sel_i) < 32'(NUM_SRC));

  assign last_s      = (idx_q == (len_q - LEN_W'(1)));
  assign next_last_s = ((idx_q + LEN_W'(1)) == (len_q - LEN_W'(1)));

  // Beat 0 is the top byte of the used field, so beat k sits at byte len-1-k of the slot.
  assign load_idx_s = valid_q ? (idx_q + LEN_W'(1)) : idx_q;
  assign byte_pos_s = len_q - load_idx_s - LEN_W'(1);
  assign off_s      = OFF_W'(32'(sel_q) * 32'(SLOT_W) + 32'(byte_pos_s) * 32'd8);
  assign payload_s  = src_data_i[off_s +: 8];

  generate
    if (CRC_EN != 0) begin : g_crc
      crc8_byte_unit #(
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
      ) u_crc (
        .clk_i     (sys_clk_i),
        .rst_i     (rst_i),
        .seed_i    (crc_seed_s),
        .en_i      (crc_en_s),
        .byte_i    (data_q),
        .crc_nxt_o (crc_nxt_s)
      );
    end else begin : g_no_crc
      logic unused_crc_s;
      assign unused_crc_s = ^{crc_seed_s, crc_en_s, CRC_POLY, CRC_INIT};
      assign crc_nxt_s    = 8'h00;
    end
  endgenerate

  // Next-state, counters and next output-register values.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    idx_d      = idx_q;
    len_d      = len_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    data_d     = data_q;
    sof_d      = sof_q;
    eof_d      = eof_q;
    err_d      = 1'b0;
    drop_d     = trig_s & (state_q != ST_IDLE);
    crc_seed_s = 1'b0;
    crc_en_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        crc_seed_s = 1'b1;
        if (trig_s && req_ok_s) begin
          sel_d   = src_sel_i;
          len_d   = len_i;
          idx_d   = '0;
          gap_d   = '0;
          state_d = (GAP_CYC == 0) ? ST_DATA : ST_GAP;
        end else begin
          err_d = trig_s;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_DATA;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      ST_DATA: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          data_d  = payload_s;
          sof_d   = (idx_q == '0);
          eof_d   = (CRC_EN == 0) && last_s;
        end else if (ready_i) begin
          crc_en_s = 1'b1;
          sof_d    = 1'b0;
          if (last_s && (CRC_EN != 0)) begin
            state_d = ST_CRC;
            data_d  = crc_nxt_s;
            eof_d   = 1'b1;
          end else if (last_s) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            eof_d   = 1'b0;
          end else begin
            idx_d  = idx_q + LEN_W'(1);
            data_d = payload_s;
            eof_d  = (CRC_EN == 0) && next_last_s;
          end
        end else begin
          valid_d = valid_q;
        end
      end

      ST_CRC: begin
        if (ready_i) begin
          state_d = ST_DONE;
          valid_d = 1'b0;
          eof_d   = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end

      ST_DONE: begin
        crc_seed_s = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
      end
    endcase
  end

  // Registered state and outputs; start history resets high so a held start cannot trigger.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      start_q <= 1'b1;
      gap_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      busy_q  <= (state_d != ST_IDLE);
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sof_o   = sof_q;
  assign eof_o   = eof_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;
  assign drop_o  = drop_q;

endmodule

// File: tb/tb_frame_gen_stream.sv
// Directed bench: instance A uses the default build (gap 50, CRC on); instance B is a
// small build (5 slots x 4 bytes, no gap, no CRC).
module tb_frame_gen_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          a_start, a_ready;
  logic [2:0]    a_sel;
  logic [6:0]    a_len;
  logic [4095:0] a_src;
  logic [7:0]    a_data;
  logic          a_valid, a_sof, a_eof, a_busy, a_err, a_drop;

  logic          b_start, b_ready;
  logic [2:0]    b_sel;
  logic [2:0]    b_len;
  logic [159:0]  b_src;
  logic [7:0]    b_data;
  logic          b_valid, b_sof, b_eof, b_busy, b_err, b_drop;

  int total = 0;
  int bad   = 0;

  logic [7:0] cap_d   [0:15];
  logic       cap_sof [0:15];
  logic       cap_eof [0:15];
  int         ncap;

  frame_gen_stream u_a (
    .sys_clk_i (clk),     .rst_i   (rst),     .start_i (a_start),
    .src_sel_i (a_sel),   .len_i   (a_len),   .src_data_i (a_src),
    .data_o    (a_data),  .valid_o (a_valid), .ready_i (a_ready),
    .sof_o     (a_sof),   .eof_o   (a_eof),   .busy_o  (a_busy),
    .err_o     (a_err),   .drop_o  (a_drop)
  );

  frame_gen_stream #(
    .NUM_SRC (5), .SRC_BYTES (4), .GAP_CYC (0), .CRC_EN (0)
  ) u_b (
    .sys_clk_i (clk),     .rst_i   (rst),     .start_i (b_start),
    .src_sel_i (b_sel),   .len_i   (b_len),   .src_data_i (b_src),
    .data_o    (b_data),  .valid_o (b_valid), .ready_i (b_ready),
    .sof_o     (b_sof),   .eof_o   (b_eof),   .busy_o  (b_busy),
    .err_o     (b_err),   .drop_o  (b_drop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid_a(output int cyc);
    cyc = 0;
    while (a_valid !== 1'b1 && cyc < 300) begin
      step();
      cyc++;
    end
  endtask

  // Accepts beats until eof is taken; ends just after the accepting edge.
  task automatic collect_a(input bit toggle);
    logic        ph;
    logic        stall;
    logic        done;
    logic [10:0] held;
    ncap  = 0;
    ph    = 1'b1;
    stall = 1'b0;
    done  = 1'b0;
    held  = '0;
    for (int c = 0; c < 60 && !done; c++) begin
      a_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (stall) chk("stall_hold", 32'({a_valid, a_sof, a_eof, a_data}), 32'(held));
      if (a_valid && a_ready) begin
        if (ncap < 16) begin
          cap_d[ncap]   = a_data;
          cap_sof[ncap] = a_sof;
          cap_eof[ncap] = a_eof;
        end
        ncap++;
        done = a_eof;
      end
      stall = a_valid && !a_ready;
      held  = {a_valid, a_sof, a_eof, a_data};
      step();
    end
    a_ready = 1'b1;
    chk("eof_seen", 32'(done), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int n, input logic [47:0] exp_bytes);
    chk({tag, "_count"}, 32'(ncap), 32'(n));
    for (int i = 0; i < n && i < ncap; i++) begin
      chk({tag, "_byte"}, 32'(cap_d[i]), 32'(exp_bytes[(n-1-i)*8 +: 8]));
      chk({tag, "_sof"}, 32'(cap_sof[i]), 32'(i == 0));
      chk({tag, "_eof"}, 32'(cap_eof[i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    int          cyc;
    logic        saw_busy;
    logic [31:0] bvec;

    rst = 1'b1;
    a_start = 1'b1; a_ready = 1'b1; a_sel = 3'd1; a_len = 7'd5;
    b_start = 1'b1; b_ready = 1'b1; b_sel = 3'd2; b_len = 3'd1;
    a_src = '0;
    a_src[0   +: 40] = 40'hAABBCCDDEE;
    a_src[512 +: 48] = 48'h770102030405;
    a_src[1024 +: 40] = 40'h1112131415;
    b_src = '0;
    b_src[32 +: 32] = 32'h5A5A5A5A;
    b_src[64 +: 32] = 32'hA1B2C3D4;
    b_src[96 +: 32] = 32'h99887766;

    repeat (3) step();
    chk("rst_outs_a", 32'({a_valid, a_sof, a_eof, a_busy, a_err, a_drop, a_data}), 32'd0);
    chk("rst_outs_b", 32'({b_valid, b_sof, b_eof, b_busy, b_err, b_drop, b_data}), 32'd0);
    rst = 1'b0;
    step();
    step();
    chk("held_start_no_trig_a", 32'({a_busy, a_valid}), 32'd0);
    chk("held_start_no_trig_b", 32'({b_busy, b_valid}), 32'd0);
    a_start = 1'b0; b_start = 1'b0;
    step();

    // Frame with ready held high: 01..05 then CRC 0xBC.
    a_start = 1'b1;
    step();
    chk("t1_busy_after_trig", 32'({a_busy, a_valid}), 32'h2);
    wait_valid_a(cyc);
    chk("t1_latency", 32'(cyc), 32'd51);
    collect_a(1'b0);
    check_frame("t1", 6, 48'h0102030405BC);
    chk("t1_done_state", 32'({a_busy, a_valid}), 32'h2);
    step();
    chk("t1_idle_busy", 32'(a_busy), 32'd0);

    // Same frame with ready toggling.
    a_start = 1'b0;
    step();
    a_start = 1'b1;
    step();
    wait_valid_a(cyc);
    chk("t2_latency", 32'(cyc), 32'd51);
    collect_a(1'b1);
    check_frame("t2", 6, 48'h0102030405BC);
    step();

    // Rejected triggers.
    a_start = 1'b0; a_len = 7'd0;
    step();
    a_start = 1'b1;
    step();
    chk("t3_len0_err", 32'({a_err, a_busy, a_valid}), 32'h4);
    step();
    chk("t3_err_pulse", 32'({a_err, a_busy, a_valid}), 32'h0);
    a_start = 1'b0; a_len = 7'd65;
    step();
    a_start = 1'b1;
    step();
    chk("t3_len65_err", 32'({a_err, a_busy, a_valid}), 32'h4);
    a_start = 1'b0;
    b_sel = 3'd5; b_len = 3'd1; b_start = 1'b1;
    step();
    chk("t3_sel5_err_b", 32'({b_err, b_busy, b_valid}), 32'h4);
    b_start = 1'b0; b_sel = 3'd2; b_len = 3'd5;
    step();
    b_start = 1'b1;
    step();
    chk("t3_len5_err_b", 32'({b_err, b_busy, b_valid}), 32'h4);
    b_start = 1'b0; b_len = 3'd1;
    a_len = 7'd5;
    step();

    // Retrigger during the gap is dropped; frame unaffected.
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    repeat (9) step();
    a_start = 1'b1;
    step();
    chk("t4_drop_pulse", 32'(a_drop), 32'd1);
    step();
    chk("t4_drop_clear", 32'(a_drop), 32'd0);
    wait_valid_a(cyc);
    chk("t4_latency_rest", 32'(cyc), 32'd40);
    collect_a(1'b0);
    check_frame("t4", 6, 48'h0102030405BC);
    a_start = 1'b0; a_len = 7'd1;
    step();
    a_start = 1'b1;
    step();
    wait_valid_a(cyc);
    chk("t4b_latency", 32'(cyc), 32'd51);
    collect_a(1'b0);
    check_frame("t4b", 2, 48'h00000000051B);

    // Reset during beat 2 with start held high.
    a_start = 1'b0; a_len = 7'd5;
    step();
    a_start = 1'b1;
    step();
    wait_valid_a(cyc);
    step();
    step();
    chk("t5_beat2", 32'({a_valid, a_data}), 32'h103);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_abort", 32'({a_valid, a_busy, a_eof}), 32'd0);
    saw_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      saw_busy = saw_busy | a_busy | a_valid;
    end
    chk("t5_no_restart", 32'(saw_busy), 32'd0);
    a_start = 1'b0;
    step();
    a_start = 1'b1;
    step();
    chk("t5_retrig_busy", 32'(a_busy), 32'd1);
    wait_valid_a(cyc);
    chk("t5_latency", 32'(cyc), 32'd51);
    collect_a(1'b0);
    check_frame("t5", 6, 48'h0102030405BC);

    // No-gap, no-CRC build, single-byte frame.
    b_sel = 3'd2; b_len = 3'd1; b_start = 1'b1;
    step();
    chk("t6_trig", 32'({b_busy, b_valid}), 32'h2);
    step();
    chk("t6_beat", 32'({b_valid, b_sof, b_eof, b_data}), 32'h7D4);
    step();
    chk("t6_done", 32'({b_busy, b_valid}), 32'h2);
    step();
    chk("t6_idle", 32'(b_busy), 32'd0);

    // Full-slot frame on the small build.
    b_start = 1'b0; b_len = 3'd4;
    step();
    b_start = 1'b1;
    step();
    bvec = 32'hA1B2C3D4;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_len4_beat", 32'({b_valid, b_sof, b_eof, b_data}),
          32'({1'b1, (i == 0), (i == 3), bvec[(3-i)*8 +: 8]}));
    end
    step();
    chk("t6_len4_end", 32'(b_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
